// File: rtl/gpgpu_arb_pkg.sv
// Shared arbitration constants and helpers for the GPGPU arbiter slice.
package gpgpu_arb_pkg;

   localparam int unsigned ARB_NUM_REQ    = 32;
   localparam int unsigned ARB_DATA_WIDTH = 32;

   // Modular increment: idx+1 wrapping to 0 at n (n need not be a power of two).
   function automatic int unsigned rr_next_idx(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority encoder: first set request after ptr wins.
module rr_priority_pick
   import gpgpu_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ   = ARB_NUM_REQ,
   parameter int unsigned SEL_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]   req,
   input  logic [SEL_WIDTH-1:0] ptr,
   output logic                 any,
   output logic [SEL_WIDTH-1:0] winner,
   output logic [NUM_REQ-1:0]   onehot
);

   int unsigned idx;

   // Scan ptr+1, ptr+2, ... modulo NUM_REQ and keep the first requester found.
   always_comb begin
      any    = 1'b0;
      winner = '0;
      onehot = '0;
      idx    = rr_next_idx(int'(ptr), NUM_REQ);
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!any && idx < NUM_REQ && req[SEL_WIDTH'(idx)]) begin
            any    = 1'b1;
            winner = SEL_WIDTH'(idx);
         end
         idx = rr_next_idx(idx, NUM_REQ);
      end
      if (any) onehot = NUM_REQ'(1) << winner;
   end

endmodule

// File: rtl/rr_select_stage.sv
// Round-robin arbiter steering an external N:1 mux, with a registered
// valid/ready output stage capturing the mux result and winner id.
// Optional burst lock: define RR_SELECT_LOCK_EN to add the req_lock port.
module rr_select_stage
   import gpgpu_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = ARB_NUM_REQ,
   parameter int unsigned DATA_WIDTH = ARB_DATA_WIDTH,
   parameter int unsigned SEL_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
`ifdef RR_SELECT_LOCK_EN
   input  logic [NUM_REQ-1:0]    req_lock,
`endif
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [SEL_WIDTH-1:0]  sel,
   input  logic [DATA_WIDTH-1:0] mux_out,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [SEL_WIDTH-1:0]  out_sel,
   input  logic                  out_ready
);

   logic [SEL_WIDTH-1:0] ptr;
   logic                 pick_any;
   logic [SEL_WIDTH-1:0] pick_idx;
   logic [NUM_REQ-1:0]   pick_onehot;
   logic                 lock_hit;
   logic [SEL_WIDTH-1:0] winner;
   logic [NUM_REQ-1:0]   win_onehot;
   logic                 can_accept;
   logic                 grant;

   rr_priority_pick #(
      .NUM_REQ   (NUM_REQ),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_pick (
      .req    (req_valid),
      .ptr    (ptr),
      .any    (pick_any),
      .winner (pick_idx),
      .onehot (pick_onehot)
   );

`ifdef RR_SELECT_LOCK_EN
   // Last grantee keeps the bus while it holds both lock and request.
   always_comb lock_hit = req_lock[ptr] && req_valid[ptr];
`else
   // Pure round-robin: no burst continuation.
   always_comb lock_hit = 1'b0;
`endif

   // Winner selection, mux steering and grant generation.
   always_comb begin
      winner     = lock_hit ? ptr : pick_idx;
      win_onehot = lock_hit ? (NUM_REQ'(1) << ptr) : pick_onehot;
      sel        = pick_any ? winner : '0;
      can_accept = !out_valid || out_ready;
      grant      = pick_any && can_accept && !rst;
      req_ready  = grant ? win_onehot : '0;
   end

   // Output register and rotation pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= SEL_WIDTH'(NUM_REQ - 1);
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
      end else if (grant) begin
         ptr       <= winner;
         out_valid <= 1'b1;
         out_data  <= mux_out;
         out_sel   <= winner;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
